// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the EX/MEM hazard sequencer:
//            forwarding-select encoding, hazard FSM states and the
//            register-address width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int REG_AW = 5;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // register-file value
    FWD_WB  = 2'b01,  // write-back data
    FWD_MEM = 2'b10   // ALU result held in MEM
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LDSTALL = 2'd1,
    HZ_FLUSH   = 2'd2,
    HZ_MEMWAIT = 2'd3
  } hz_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Combinational forwarding match for one EX source operand.
//            An EX-stage ALU producer wins over a MEM-stage producer; a load
//            in EX is never forwarded from EX (its data is not ready yet);
//            register 0 is never forwarded.
// Ports    : rs        in  AW  source register of the ID instruction
//            dst_exe   in  AW  EX destination
//            wen_exe   in  1   EX writes a register
//            rd_en_exe in  1   EX instruction is a load
//            dst_mem   in  AW  MEM destination
//            wen_mem   in  1   MEM writes a register
//            sel       out 2   operand source select
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
  import pipe_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] dst_exe,
  input  logic          wen_exe,
  input  logic          rd_en_exe,
  input  logic [AW-1:0] dst_mem,
  input  logic          wen_mem,
  output fwd_sel_t      sel
);

  always_comb begin
    sel = FWD_REG;
    if (rs != '0) begin
      if ((rs == dst_exe) && wen_exe && !rd_en_exe) begin
        sel = FWD_MEM;
      end else if ((rs == dst_mem) && wen_mem) begin
        sel = FWD_WB;
      end
    end
  end

endmodule : fwd_select
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : EX/MEM pipeline sequencer. Registers forwarding selects and
//            arbitrates data-memory wait stalls, branch flushes and load-use
//            bubbles so exactly one pipeline action happens per cycle.
//            Optional macro HAZARD_PERF_CNT_EN adds stall/flush counters.
// Ports    : clk, rst_n                    clock, async active-low reset
//            rs1_id, rs2_id                ID source registers
//            wrt_dst_exe, reg_wrt_en_exe,
//            rd_en_exe                     EX producer (rd_en = load)
//            wrt_dst_mem, reg_wrt_en_mem   MEM producer
//            mem_req_mem, mem_ready        data-memory handshake
//            branch                        taken branch resolved in EX
//            forward_control1/2            EX operand A/B source select
//            stall_if, stall_id, stall_mem pipeline holds
//            flush_id, flush_ex            bubble insertion
//            mem_timeout                   sticky memory-wait timeout
//            stall_cycles, flush_count     (HAZARD_PERF_CNT_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW     = pipe_pkg::REG_AW,
  parameter int MEM_TO_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] wrt_dst_exe,
  input  logic              reg_wrt_en_exe,
  input  logic              rd_en_exe,
  input  logic [REG_AW-1:0] wrt_dst_mem,
  input  logic              reg_wrt_en_mem,
  input  logic              mem_req_mem,
  input  logic              mem_ready,
  input  logic              branch,
  output logic [1:0]        forward_control1,
  output logic [1:0]        forward_control2,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
`endif
  output logic              mem_timeout
);

  import pipe_pkg::*;

  localparam int             CNT_W   = $clog2(MEM_TO_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TO_MAX);

  hz_state_t        state, next_state;
  fwd_sel_t         sel1, sel2;
  fwd_sel_t         fwd1, fwd2;
  logic [CNT_W-1:0] wait_cnt, cnt_inc;
  logic             load_use, mem_wait;

  fwd_select #(.AW(REG_AW)) u_fwd1 (
    .rs(rs1_id), .dst_exe(wrt_dst_exe), .wen_exe(reg_wrt_en_exe),
    .rd_en_exe(rd_en_exe), .dst_mem(wrt_dst_mem), .wen_mem(reg_wrt_en_mem),
    .sel(sel1)
  );

  fwd_select #(.AW(REG_AW)) u_fwd2 (
    .rs(rs2_id), .dst_exe(wrt_dst_exe), .wen_exe(reg_wrt_en_exe),
    .rd_en_exe(rd_en_exe), .dst_mem(wrt_dst_mem), .wen_mem(reg_wrt_en_mem),
    .sel(sel2)
  );

  assign load_use = rd_en_exe && reg_wrt_en_exe && (wrt_dst_exe != '0) &&
                    ((wrt_dst_exe == rs1_id) || (wrt_dst_exe == rs2_id));
  assign mem_wait = mem_req_mem && !mem_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HZ_RUN;
    else        state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  // The load-use bubble needs no extra state: the stall itself holds ID and
  // the producer moves to MEM, so RUN naturally sees the hazard clear.
  always_comb begin
    next_state = state;
    unique case (state)
      HZ_RUN: begin
        if (mem_wait)    next_state = HZ_MEMWAIT;
        else if (branch) next_state = HZ_FLUSH;
        else             next_state = HZ_RUN;
      end
      HZ_MEMWAIT: next_state = mem_ready ? HZ_RUN : HZ_MEMWAIT;
      default:    next_state = HZ_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    unique case (state)
      HZ_RUN: begin
        if (mem_wait) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_mem = 1'b1;
        end else if (branch) begin
          // a dependent op behind the branch is killed, so no stall here
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      HZ_MEMWAIT: begin
        // branch is ignored here; EX is held so it re-presents in RUN
        if (!mem_ready) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_mem = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- forwarding select registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd1 <= FWD_REG;
      fwd2 <= FWD_REG;
    end else if (flush_ex) begin
      fwd1 <= FWD_REG;
      fwd2 <= FWD_REG;
    end else if (!stall_mem) begin
      fwd1 <= sel1;
      fwd2 <= sel2;
    end
  end

  assign forward_control1 = fwd1;
  assign forward_control2 = fwd2;

  // ---------------- memory-wait counter and timeout ----------------
  assign cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == HZ_MEMWAIT && !mem_ready) begin
      wait_cnt <= cnt_inc;
      // flag rises on the cycle the count reaches the limit, then sticks
      if (cnt_inc == CNT_MAX) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_if) stall_cycles <= stall_cycles + 32'd1;
      if (flush_id) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, wrt_dst_exe, wrt_dst_mem;
  logic       reg_wrt_en_exe, rd_en_exe, reg_wrt_en_mem;
  logic       mem_req_mem, mem_ready, branch;
  logic [1:0] forward_control1, forward_control2;
  logic       stall_if, stall_id, stall_mem, flush_id, flush_ex, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .MEM_TO_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .wrt_dst_exe(wrt_dst_exe), .reg_wrt_en_exe(reg_wrt_en_exe), .rd_en_exe(rd_en_exe),
    .wrt_dst_mem(wrt_dst_mem), .reg_wrt_en_mem(reg_wrt_en_mem),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready), .branch(branch),
    .forward_control1(forward_control1), .forward_control2(forward_control2),
    .stall_if(stall_if), .stall_id(stall_id), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock, land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; wrt_dst_exe = '0; wrt_dst_mem = '0;
    reg_wrt_en_exe = 0; rd_en_exe = 0; reg_wrt_en_mem = 0;
    mem_req_mem = 0; mem_ready = 0; branch = 0;
  endtask

  // stall_if,stall_id,stall_mem,flush_id,flush_ex
  function automatic logic [4:0] ctl();
    return {stall_if, stall_id, stall_mem, flush_id, flush_ex};
  endfunction

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    // ---- reset state ----
    check("rst_ctl", ctl(), 5'b00000);
    check("rst_fwd1", forward_control1, 2'b00);
    check("rst_fwd2", forward_control2, 2'b00);
    check("rst_tmo", mem_timeout, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---- ALU dep: EX x5 (also MEM x5) -> EX wins on rs1 ----
    wrt_dst_exe = 5'd5; reg_wrt_en_exe = 1;
    wrt_dst_mem = 5'd5; reg_wrt_en_mem = 1;
    rs1_id = 5'd5; rs2_id = 5'd4;
    #1 check("alu_nostall", ctl(), 5'b00000);
    tick();
    check("alu_fwd1", forward_control1, 2'b10);
    check("alu_fwd2", forward_control2, 2'b00);

    // ---- MEM match on rs1, EX match on rs2 ----
    wrt_dst_exe = 5'd8; wrt_dst_mem = 5'd4;
    rs1_id = 5'd4; rs2_id = 5'd8;
    tick();
    check("mix_fwd1", forward_control1, 2'b01);
    check("mix_fwd2", forward_control2, 2'b10);

    // ---- x0 never forwards ----
    wrt_dst_exe = 5'd0; wrt_dst_mem = 5'd0;
    rs1_id = 5'd0; rs2_id = 5'd0;
    #1 check("x0_nostall", ctl(), 5'b00000);
    tick();
    check("x0_fwd1", forward_control1, 2'b00);
    check("x0_fwd2", forward_control2, 2'b00);

    // ---- load-use on rs2 = x7 ----
    clear_inputs();
    rd_en_exe = 1; reg_wrt_en_exe = 1; wrt_dst_exe = 5'd7;
    rs1_id = 5'd1; rs2_id = 5'd7;
    #1 check("ldu_ctl", ctl(), 5'b11001);
    tick();
    check("ldu_fwd2_bubble", forward_control2, 2'b00);
    // load has moved to MEM, bubble in EX
    rd_en_exe = 0; reg_wrt_en_exe = 0; wrt_dst_exe = 5'd0;
    wrt_dst_mem = 5'd7; reg_wrt_en_mem = 1;
    #1 check("ldu_once", ctl(), 5'b00000);
    tick();
    check("ldu_fwd2_wb", forward_control2, 2'b01);

    // ---- branch + load-use same cycle -> flush only, selects cleared ----
    clear_inputs();
    rd_en_exe = 1; reg_wrt_en_exe = 1; wrt_dst_exe = 5'd7;
    rs2_id = 5'd7; branch = 1;
    #1 check("br_ldu_ctl", ctl(), 5'b00011);
    tick();
    check("br_fwd2_clr", forward_control2, 2'b00);
    branch = 0;
    // FLUSH cycle asserts nothing even with the load-use pattern present
    #1 check("flush_quiet", ctl(), 5'b00000);
    tick();
    clear_inputs();

    // ---- MEMWAIT with timeout, held selects, ignored branch ----
    wrt_dst_exe = 5'd3; reg_wrt_en_exe = 1; rs1_id = 5'd3;
    tick();
    check("mw_pre_fwd1", forward_control1, 2'b10);
    rs1_id = 5'd0;  // would give 00 if the select were not held
    mem_req_mem = 1; mem_ready = 0;
    #1 check("mw_enter_ctl", ctl(), 5'b11100);
    tick();
    branch = 1;
    for (int k = 1; k <= 15; k++) begin
      #1 check($sformatf("mw_ctl_%0d", k), ctl(), 5'b11100);
      tick();
      check($sformatf("mw_tmo_%0d", k), mem_timeout, (k >= 15) ? 1'b1 : 1'b0);
    end
    check("mw_fwd1_hold", forward_control1, 2'b10);
    mem_ready = 1;
    #1 check("mw_exit_ctl", ctl(), 5'b00000);
    tick();
    mem_req_mem = 0; mem_ready = 0;
    #1 check("mw_branch_replay", ctl(), 5'b00011);
    tick();
    branch = 0;
    #1 check("mw_post_flush", ctl(), 5'b00000);
    check("mw_tmo_sticky", mem_timeout, 1'b1);
    tick();

    // ---- reset mid-MEMWAIT ----
    mem_req_mem = 1; mem_ready = 0;
    repeat (3) tick();
    #1 check("mw2_ctl", ctl(), 5'b11100);
    rst_n = 0; mem_req_mem = 0;
    #1 check("arst_ctl", ctl(), 5'b00000);
    check("arst_tmo", mem_timeout, 1'b0);
    check("arst_fwd1", forward_control1, 2'b00);
    tick();
    check("arst_edge_ctl", ctl(), 5'b00000);
    rst_n = 1;
    mem_req_mem = 1;
    #1 check("post_rst_run", ctl(), 5'b11100);
    tick();
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
